jtopll_reg_bank: RTL and testbench
==================================

// Module: jtopll_reg_bank
// PURPOSE
//  Parametrised OPLL-family register bank: CPU register file, instrument patch memory and slot
//  sequencer in one block. Each cen it presents the registered operator parameters for one slot
//  to the PG/EG/OP stages. Generalises the fixed 9-channel bank:
//  - channel count and patch depth are parameters
//  - rhythm mode is handled by the sequencer
//  - optional CPU readback port
// PARAMETERS
//  CH      9   channels; frame = 2*CH slots; legal range 1..16
//  NPATCH  16  melodic patches incl. user patch 0; patches 1..NPATCH-1 loaded via prog port
//  NDRUM   6   rhythm patches, stored after melodic ones; 0 removes rhythm mode
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset; asynchronous, active-high
//  cen        in   1   slot advance enable
//  cpu_we     in   1   CPU register write strobe; one write per clk
//  cpu_addr   in   6   register address
//  cpu_din    in   8   write data
//  prog_we    in   1   patch load strobe
//  prog_addr  in   $clog2(NPATCH+NDRUM)+3  {patch, byte}
//  prog_data  in   8   patch byte
//  zero       out  1   high while the output slot is ch0/op0
//  ch         out  4   channel of output slot
//  op         out  1   0 = modulator, 1 = carrier
//  fnum       out  9   frequency number
//  block      out  3   octave
//  keyon      out  1   key on
//  en_sus     out  1   sustain enable
//  mul        out  4   multiplier
//  ks,am,vib  out  1 each  key scale / AM enable / vibrato enable
//  ksl        out  2   key-scale level
//  tl         out  6   total level; carrier = {vol,2'b0}
//  fb         out  3   feedback; 0 on carrier
//  wav        out  1   half-sine select
//  ar,dr,sl,rr out 4 each  envelope rates / sustain level
//  con        out  1   add operator to accumulator
//  rd_data    out  8   readback; present only with JTOPLL_RDBACK_EN
// BEHAVIOUR
//  Reset: every storage element and every output is 0; sequencer holds ch0/op0.
//   zero stays 0 until the first cen.
//  Sequencer: {cnt_ch,cnt_op} with op toggling fastest, ch wrapping CH-1 -> 0.
//   Each cen: outputs register the parameters of the current count; the count then advances.
//   Latency: one cen from count to outputs. zero=1 for exactly one slot per frame.
//   Without cen, all outputs hold.
//  CPU map (writes take effect next clk):
//   0x00-0x07 user patch bytes
//   0x0E      rhythm {-,-,rhy_en,BD,SD,TOM,CY,HH}
//   0x10+c    fnum[7:0]
//   0x20+c    {sus,kon,block,fnum[8]}
//   0x30+c    {inst,vol}
//   Ignored, no side effect: c>=CH, undecoded addresses, any addr with cpu_we low.
//  Read-before-write: a write landing on the clk the same channel is being sampled is seen on
//   the next visit, never mid-slot. Carrier of a channel always uses the same snapshot as its
//   modulator (sample chcfg once per channel, at op0).
//  Patch byte layout: 0/1 AM,VIB,EG,KS,MUL (mod/car); 2 KSL_mod,TL; 3 KSL_car,-,WC,WM,FB;
//   4/5 AR,DR; 6/7 SL,RR. prog and CPU writes may coincide; both complete (different patches).
//  Rhythm (rhy_en=1, NDRUM>0, CH>=9): channels 6..8 use drum patch NPATCH+(2*(ch-6)+op).
//   - keyon from the matching rhythm bit
//   - con=1 except ch6 (BD)
//   - ch7/ch8 modulator tl = inst<<2
//   Clearing rhy_en mid-frame takes effect from the next sampled channel.
//  Reset mid-frame: sequencer returns to ch0/op0 asynchronously; CPU and patch contents are
//   lost (prog data must be reloaded).
// CONFIGURATION
//  JTOPLL_RDBACK_EN defined:
//   rd_data = register last written at cpu_addr, combinational from storage; unmapped -> 8'hFF.
//  JTOPLL_RDBACK_EN undefined: rd_data port absent; no readback muxes built.
// STRUCTURE
//  Shared package jtopll_pkg:
//   - register address constants (REG_USR, REG_RHY, REG_FLO, REG_FHI, REG_INS)
//   - patch byte offsets
//   - chcfg struct {sus,kon,block,fnum,inst,vol}
//  Sub-module jtopll_slot_seq: counters, zero, rhythm slot decode.
//  Top keeps the storage and the output register stage.
// TESTING
//  1 Reset, 2*CH cen with CH=9 -> ch/op walk 0/0,0/1..8/1; zero high once; all params 0.
//  2 Write 0x10=0x55, 0x20=0x1B, 0x30=0x3A, cen to ch0 -> fnum=0x155, block=5, keyon=1.
//    Also: inst=3 params; carrier tl=0x28.
//  3 Write 0x10+ch2 on the clk ch2/op0 is sampled -> old fnum this frame, new next; op1 = op0.
//  4 Write 0x0E=0x30, drum patch 16 AR=0xF -> ch6 op0 ar=F, keyon=1, con=0; ch7 con=1.
//  5 CH=12 build: writes to 0x1B land on ch11; 0x1C ignored; frame is 24 slots.
//  6 RDBACK_EN build: write 0x33=0x7C -> rd_data=0x7C at 0x33; 0x3F -> 0xFF; reset -> 0x00.

Source files
------------

// File: rtl/jtopll_pkg.sv
// Shared definitions for the OPLL register bank.
//  - CPU register address constants
//  - instrument patch byte offsets
//  - per-channel configuration snapshot (chcfg_t)
//  - channel-range helper used by the address decode
package jtopll_pkg;

    // CPU register map (6-bit address space)
    localparam logic [5:0] REG_USR = 6'h00;   // 0x00-0x07 user patch bytes
    localparam logic [5:0] REG_RHY = 6'h0E;   // {-,-,rhy_en,BD,SD,TOM,CY,HH}
    localparam logic [5:0] REG_FLO = 6'h10;   // 0x10+c fnum[7:0]
    localparam logic [5:0] REG_FHI = 6'h20;   // 0x20+c {sus,kon,block,fnum[8]}
    localparam logic [5:0] REG_INS = 6'h30;   // 0x30+c {inst,vol}

    // Patch byte offsets inside one 8-byte instrument
    localparam int PB_MULT  = 0;   // +op : AM,VIB,EG,KS,MUL
    localparam int PB_KSLTL = 2;   // KSL_mod,TL_mod
    localparam int PB_FB    = 3;   // KSL_car,-,WC,WM,FB
    localparam int PB_ADR   = 4;   // +op : AR,DR
    localparam int PB_SLRR  = 6;   // +op : SL,RR

    // Rhythm register bit positions
    localparam int RHY_EN = 5;
    localparam int RHY_BD = 4;
    localparam int RHY_SD = 3;
    localparam int RHY_TOM = 2;
    localparam int RHY_CY = 1;
    localparam int RHY_HH = 0;

    typedef struct packed {
        logic       sus;
        logic       kon;
        logic [2:0] block;
        logic [8:0] fnum;
        logic [3:0] inst;
        logic [3:0] vol;
    } chcfg_t;

    function automatic logic ch_in_range(input logic [3:0] c, input int n);
        return int'(c) < n;
    endfunction

endpackage

// File: rtl/jtopll_slot_seq.sv
// Slot sequencer for the OPLL register bank.
//  Walks {cnt_ch,cnt_op} across the 2*CH slot frame, op toggling fastest.
//  Also decodes whether the current slot is a rhythm slot and which drum patch it uses.
// Ports:
//  clk, rst      clock, asynchronous active-high reset
//  cen           slot advance enable
//  rhy_en        effective rhythm enable for the current slot
//  cur_ch/cur_op count being sampled this cen (combinational)
//  rhy_slot      current slot is a rhythm slot (ch6..8 with rhythm enabled)
//  drum_idx      drum patch offset 2*(ch-6)+op
//  zero, ch, op  registered slot identity, aligned with the parameter outputs
module jtopll_slot_seq #(
    parameter int CH    = 9,
    parameter int NDRUM = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       rhy_en,
    output logic [3:0] cur_ch,
    output logic       cur_op,
    output logic       rhy_slot,
    output logic [2:0] drum_idx,
    output logic       zero,
    output logic [3:0] ch,
    output logic       op
);

    localparam logic [3:0] LAST_CH = 4'(CH - 1);
    localparam bit         RHY_OK  = (NDRUM > 0) && (CH >= 9);

    logic [3:0] cnt_ch;
    logic       cnt_op;

    assign cur_ch = cnt_ch;
    assign cur_op = cnt_op;

    always_comb begin
        rhy_slot = RHY_OK && rhy_en && (cnt_ch >= 4'd6) && (cnt_ch <= 4'd8);
        drum_idx = {2'(cnt_ch - 4'd6), cnt_op};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_ch <= '0;
            cnt_op <= 1'b0;
            zero   <= 1'b0;
            ch     <= '0;
            op     <= 1'b0;
        end else if (cen) begin
            zero   <= (cnt_ch == 4'd0) && !cnt_op;
            ch     <= cnt_ch;
            op     <= cnt_op;
            cnt_op <= ~cnt_op;
            if (cnt_op)
                cnt_ch <= (cnt_ch == LAST_CH) ? 4'd0 : cnt_ch + 4'd1;
        end
    end

endmodule

// File: rtl/jtopll_reg_bank.sv
// OPLL-family register bank: CPU register file, instrument patch memory and slot sequencer.
//  Each cen the outputs register the operator parameters of one slot.
// Ports:
//  clk, rst              clock, asynchronous active-high reset
//  cen                   slot advance enable
//  cpu_we/addr/din       CPU register write port
//  prog_we/addr/data     patch load port, addr = {patch, byte}; patch 0 belongs to the CPU
//  zero, ch, op          slot identity (zero marks ch0/op0)
//  fnum..con             registered operator parameters
//  rd_data               CPU readback, only when JTOPLL_RDBACK_EN is defined
// Configuration macro: JTOPLL_RDBACK_EN adds the combinational readback port.
module jtopll_reg_bank
    import jtopll_pkg::*;
#(
    parameter int CH     = 9,
    parameter int NPATCH = 16,
    parameter int NDRUM  = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cen,
    input  logic                                cpu_we,
    input  logic [5:0]                          cpu_addr,
    input  logic [7:0]                          cpu_din,
    input  logic                                prog_we,
    input  logic [$clog2(NPATCH+NDRUM)+2:0]     prog_addr,
    input  logic [7:0]                          prog_data,
    output logic                                zero,
    output logic [3:0]                          ch,
    output logic                                op,
    output logic [8:0]                          fnum,
    output logic [2:0]                          block,
    output logic                                keyon,
    output logic                                en_sus,
    output logic [3:0]                          mul,
    output logic                                ks,
    output logic                                am,
    output logic                                vib,
    output logic [1:0]                          ksl,
    output logic [5:0]                          tl,
    output logic [2:0]                          fb,
    output logic                                wav,
    output logic [3:0]                          ar,
    output logic [3:0]                          dr,
    output logic [3:0]                          sl,
    output logic [3:0]                          rr,
    output logic                                con
`ifdef JTOPLL_RDBACK_EN
    ,
    output logic [7:0]                          rd_data
`endif
);

    localparam int NP = NPATCH + NDRUM;
    localparam int PW = $clog2(NP);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [7:0] pmem [NP][8];
    logic [5:0] rhy;
    logic [7:0] flo  [CH];
    logic [5:0] fhi  [CH];
    logic [7:0] ins  [CH];

    logic [3:0]    wc;
    logic          wr_usr, wr_rhy, wr_flo, wr_fhi, wr_ins;
    logic [PW-1:0] prog_patch;
    logic [2:0]    prog_byte;
    logic          prog_ok;

    assign wc         = cpu_addr[3:0];
    assign prog_patch = prog_addr[PW+2:3];
    assign prog_byte  = prog_addr[2:0];

    always_comb begin
        wr_usr  = cpu_we && (cpu_addr[5:3] == REG_USR[5:3]);
        wr_rhy  = cpu_we && (cpu_addr == REG_RHY);
        wr_flo  = cpu_we && (cpu_addr[5:4] == REG_FLO[5:4]) && ch_in_range(wc, CH);
        wr_fhi  = cpu_we && (cpu_addr[5:4] == REG_FHI[5:4]) && ch_in_range(wc, CH);
        wr_ins  = cpu_we && (cpu_addr[5:4] == REG_INS[5:4]) && ch_in_range(wc, CH);
        // patch 0 is the CPU user patch, so the two write ports never collide
        prog_ok = prog_we && (prog_patch != '0) && (int'(prog_patch) < NP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NP; p++)
                for (int b = 0; b < 8; b++)
                    pmem[p][b] <= '0;
            rhy <= '0;
            for (int c = 0; c < CH; c++) begin
                flo[c] <= '0;
                fhi[c] <= '0;
                ins[c] <= '0;
            end
        end else begin
            if (wr_usr)  pmem[0][cpu_addr[2:0]]    <= cpu_din;
            if (prog_ok) pmem[prog_patch][prog_byte] <= prog_data;
            if (wr_rhy)  rhy     <= cpu_din[5:0];
            if (wr_flo)  flo[wc] <= cpu_din;
            if (wr_fhi)  fhi[wc] <= cpu_din[5:0];
            if (wr_ins)  ins[wc] <= cpu_din;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [3:0] cur_ch;
    logic       cur_op;
    logic       rhy_slot;
    logic [2:0] drum_idx;
    logic [5:0] snap_rhy, eff_rhy;
    chcfg_t     live_cfg, snap_cfg, cfg;

    jtopll_slot_seq #(
        .CH    (CH),
        .NDRUM (NDRUM)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .rhy_en   (eff_rhy[RHY_EN]),
        .cur_ch   (cur_ch),
        .cur_op   (cur_op),
        .rhy_slot (rhy_slot),
        .drum_idx (drum_idx),
        .zero     (zero),
        .ch       (ch),
        .op       (op)
    );

    // The modulator samples the live registers; the carrier reuses that snapshot so
    // both operators of a channel always see the same configuration.
    always_comb begin
        live_cfg.sus   = fhi[cur_ch][5];
        live_cfg.kon   = fhi[cur_ch][4];
        live_cfg.block = fhi[cur_ch][3:1];
        live_cfg.fnum  = {fhi[cur_ch][0], flo[cur_ch]};
        live_cfg.inst  = ins[cur_ch][7:4];
        live_cfg.vol   = ins[cur_ch][3:0];
        cfg     = cur_op ? snap_cfg : live_cfg;
        eff_rhy = cur_op ? snap_rhy : rhy;
    end

    // ------------------------------------------------------------------
    // Patch fetch
    // ------------------------------------------------------------------
    int            pnum;
    logic          pidx_ok;
    logic [PW-1:0] pidx;
    logic [7:0]    pb [8];
    logic [7:0]    pb_mult, pb_adr, pb_slrr;
    logic          drum_kon;
    logic          drum_tl_inst;
    logic          unused_pb;

    always_comb begin
        pnum    = rhy_slot ? (NPATCH + int'(drum_idx)) : int'(cfg.inst);
        pidx_ok = pnum < NP;
        pidx    = PW'(pnum);
        for (int b = 0; b < 8; b++)
            pb[b] = pidx_ok ? pmem[pidx][b] : 8'h00;
        pb_mult = cur_op ? pb[PB_MULT+1] : pb[PB_MULT];
        pb_adr  = cur_op ? pb[PB_ADR+1]  : pb[PB_ADR];
        pb_slrr = cur_op ? pb[PB_SLRR+1] : pb[PB_SLRR];
    end

    assign unused_pb = pb[PB_FB][5];

    // drum slots: 0/1 BD, 2 HH, 3 SD, 4 TOM, 5 CY
    always_comb begin
        case (drum_idx)
            3'd0, 3'd1: drum_kon = eff_rhy[RHY_BD];
            3'd2:       drum_kon = eff_rhy[RHY_HH];
            3'd3:       drum_kon = eff_rhy[RHY_SD];
            3'd4:       drum_kon = eff_rhy[RHY_TOM];
            3'd5:       drum_kon = eff_rhy[RHY_CY];
            default:    drum_kon = 1'b0;
        endcase
        // HH/SD and TOM/CY pairs are independent outputs: both add to the mix, and the
        // HH/TOM modulators take their level from the instrument nibble
        drum_tl_inst = rhy_slot && (cur_ch != 4'd6);
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_cfg <= '0;
            snap_rhy <= '0;
            fnum     <= '0;
            block    <= '0;
            keyon    <= 1'b0;
            en_sus   <= 1'b0;
            mul      <= '0;
            ks       <= 1'b0;
            am       <= 1'b0;
            vib      <= 1'b0;
            ksl      <= '0;
            tl       <= '0;
            fb       <= '0;
            wav      <= 1'b0;
            ar       <= '0;
            dr       <= '0;
            sl       <= '0;
            rr       <= '0;
            con      <= 1'b0;
        end else if (cen) begin
            if (!cur_op) begin
                snap_cfg <= live_cfg;
                snap_rhy <= rhy;
            end
            fnum   <= cfg.fnum;
            block  <= cfg.block;
            keyon  <= rhy_slot ? drum_kon : cfg.kon;
            en_sus <= pb_mult[5] | cfg.sus;
            mul    <= pb_mult[3:0];
            ks     <= pb_mult[4];
            vib    <= pb_mult[6];
            am     <= pb_mult[7];
            ksl    <= cur_op ? pb[PB_FB][7:6] : pb[PB_KSLTL][7:6];
            if (cur_op)
                tl <= {cfg.vol, 2'b00};
            else if (drum_tl_inst)
                tl <= {cfg.inst, 2'b00};
            else
                tl <= pb[PB_KSLTL][5:0];
            fb     <= cur_op ? 3'd0 : pb[PB_FB][2:0];
            wav    <= cur_op ? pb[PB_FB][4] : pb[PB_FB][3];
            ar     <= pb_adr[7:4];
            dr     <= pb_adr[3:0];
            sl     <= pb_slrr[7:4];
            rr     <= pb_slrr[3:0];
            con    <= cur_op | drum_tl_inst;
        end
    end

`ifdef JTOPLL_RDBACK_EN
    always_comb begin
        rd_data = 8'hFF;
        if (cpu_addr[5:3] == REG_USR[5:3])
            rd_data = pmem[0][cpu_addr[2:0]];
        else if (cpu_addr == REG_RHY)
            rd_data = {2'b00, rhy};
        else if (ch_in_range(wc, CH)) begin
            case (cpu_addr[5:4])
                REG_FLO[5:4]: rd_data = flo[wc];
                REG_FHI[5:4]: rd_data = {2'b00, fhi[wc]};
                REG_INS[5:4]: rd_data = ins[wc];
                default:      rd_data = 8'hFF;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_jtopll_reg_bank.sv
module tb_jtopll_reg_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cen = 1'b0;
    logic       cen12 = 1'b0;
    logic       cpu_we = 1'b0;
    logic [5:0] cpu_addr = '0;
    logic [7:0] cpu_din = '0;
    logic       prog_we = 1'b0;
    logic [7:0] prog_addr = '0;
    logic [7:0] prog_data = '0;

    logic       zero, keyon, en_sus, ks, am, vib, wav, con, op;
    logic [3:0] ch, mul, ar, dr, sl, rr;
    logic [8:0] fnum;
    logic [2:0] block, fb;
    logic [1:0] ksl;
    logic [5:0] tl;

    logic       x_zero, x_keyon, x_en_sus, x_ks, x_am, x_vib, x_wav, x_con, x_op;
    logic [3:0] x_ch, x_mul, x_ar, x_dr, x_sl, x_rr;
    logic [8:0] x_fnum;
    logic [2:0] x_block, x_fb;
    logic [1:0] x_ksl;
    logic [5:0] x_tl;
`ifdef JTOPLL_RDBACK_EN
    logic [7:0] rd_data, x_rd_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int nxt_ch  = 0;
    int nxt_op  = 0;

    always #5 clk = ~clk;

    jtopll_reg_bank #(.CH(9), .NPATCH(16), .NDRUM(6)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .zero(zero), .ch(ch), .op(op), .fnum(fnum), .block(block), .keyon(keyon),
        .en_sus(en_sus), .mul(mul), .ks(ks), .am(am), .vib(vib), .ksl(ksl), .tl(tl),
        .fb(fb), .wav(wav), .ar(ar), .dr(dr), .sl(sl), .rr(rr), .con(con)
`ifdef JTOPLL_RDBACK_EN
        , .rd_data(rd_data)
`endif
    );

    jtopll_reg_bank #(.CH(12), .NPATCH(16), .NDRUM(6)) dut12 (
        .clk(clk), .rst(rst), .cen(cen12),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .zero(x_zero), .ch(x_ch), .op(x_op), .fnum(x_fnum), .block(x_block), .keyon(x_keyon),
        .en_sus(x_en_sus), .mul(x_mul), .ks(x_ks), .am(x_am), .vib(x_vib), .ksl(x_ksl),
        .tl(x_tl), .fb(x_fb), .wav(x_wav), .ar(x_ar), .dr(x_dr), .sl(x_sl), .rr(x_rr),
        .con(x_con)
`ifdef JTOPLL_RDBACK_EN
        , .rd_data(x_rd_data)
`endif
    );

    // ---------------- stimulus helpers ----------------
    task automatic adv_model();
        if (nxt_op == 1) nxt_ch = (nxt_ch == 8) ? 0 : nxt_ch + 1;
        nxt_op = 1 - nxt_op;
    endtask

    task automatic step();
        @(negedge clk); cen = 1'b1;
        @(negedge clk); cen = 1'b0;
        adv_model();
    endtask

    task automatic step12();
        @(negedge clk); cen12 = 1'b1;
        @(negedge clk); cen12 = 1'b0;
    endtask

    task automatic step_to(input int c, input int o);
        int guard = 0;
        while (!(nxt_ch == c && nxt_op == o) && guard < 64) begin
            step();
            guard++;
        end
        if (!(nxt_ch == c && nxt_op == o)) begin
            n_tests++; n_fail++;
            $display("FAIL step_to: slot %0d/%0d not reached within 64 cen", c, o);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk); cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
        @(negedge clk); cpu_we = 1'b0;
    endtask

    task automatic pload(input int patch, input int byte_i, input logic [7:0] d);
        @(negedge clk); prog_we = 1'b1; prog_addr = 8'(patch * 8 + byte_i); prog_data = d;
        @(negedge clk); prog_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        nxt_ch = 0; nxt_op = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int zcnt = 0;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({zero, ch, op, fnum, block, keyon, en_sus, mul, ks, am, vib, ksl, tl, fb, wav,
             ar, dr, sl, rr, con} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ch=%h op=%h fnum=%h tl=%h con=%h zero=%h, want all 0",
                     ch, op, fnum, tl, con, zero);
        end
        @(negedge clk); rst = 1'b0;
        nxt_ch = 0; nxt_op = 0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (zero !== 1'b0) begin
            n_fail++; $display("FAIL zero_before_cen: got %b want 0", zero);
        end
        for (int i = 0; i < 18; i++) begin
            step();
            n_tests++;
            if ({ch, op} !== {4'(i / 2), 1'(i % 2)}) begin
                n_fail++;
                $display("FAIL walk slot %0d: ch/op=%0d/%0d want %0d/%0d", i, ch, op, i / 2, i % 2);
            end
            n_tests++;
            if ({fnum, block, keyon, en_sus, mul, ks, am, vib, ksl, tl, fb, wav, ar, dr, sl, rr} !== '0
                || con !== op) begin
                n_fail++;
                $display("FAIL walk_params slot %0d: fnum=%h tl=%h ar=%h con=%b, want 0 (con=op)",
                         i, fnum, tl, ar, con);
            end
            if (zero === 1'b1) zcnt++;
            if (i == 0) begin
                n_tests++;
                if (zero !== 1'b1) begin
                    n_fail++; $display("FAIL zero_slot0: got %b want 1", zero);
                end
            end
        end
        n_tests++;
        if (zcnt != 1) begin
            n_fail++; $display("FAIL zero_per_frame: got %0d want 1", zcnt);
        end
        step();
        n_tests++;
        if ({zero, ch, op} !== {1'b1, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL frame_wrap: zero=%b ch=%0d op=%0d want 1/0/0", zero, ch, op);
        end
    endtask

    task automatic test_params();
        pload(3, 0, 8'h21); pload(3, 1, 8'h92); pload(3, 2, 8'h4F); pload(3, 3, 8'hDD);
        pload(3, 4, 8'hA5); pload(3, 5, 8'h37); pload(3, 6, 8'h4C); pload(3, 7, 8'h81);
        wr(6'h10, 8'h55); wr(6'h20, 8'h1B); wr(6'h30, 8'h3A);
        step_to(0, 0);
        step();
        n_tests++;
        if ({zero, ch, op, fnum, block, keyon} !== {1'b1, 4'd0, 1'b0, 9'h155, 3'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL mod_freq: zero=%b ch=%0d fnum=%h block=%0d keyon=%b want 1/0/155/5/1",
                     zero, ch, fnum, block, keyon);
        end
        n_tests++;
        if ({mul, am, vib, ks, en_sus} !== {4'd1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mod_mult: mul=%h am=%b vib=%b ks=%b en_sus=%b want 1/0/0/0/1",
                     mul, am, vib, ks, en_sus);
        end
        n_tests++;
        if ({ksl, tl, fb, wav, con} !== {2'd1, 6'h0F, 3'd5, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mod_level: ksl=%0d tl=%h fb=%0d wav=%b con=%b want 1/0F/5/1/0",
                     ksl, tl, fb, wav, con);
        end
        n_tests++;
        if ({ar, dr, sl, rr} !== 16'hA54C) begin
            n_fail++; $display("FAIL mod_env: got %h want A54C", {ar, dr, sl, rr});
        end
        step();
        n_tests++;
        if ({op, fnum, block, keyon, mul, am, vib, ks, en_sus} !==
            {1'b1, 9'h155, 3'd5, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL car_freq_mult: op=%b fnum=%h blk=%0d kon=%b mul=%h am=%b vib=%b ks=%b sus=%b",
                     op, fnum, block, keyon, mul, am, vib, ks, en_sus);
        end
        n_tests++;
        if ({ksl, tl, fb, wav, con} !== {2'd3, 6'h28, 3'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL car_level: ksl=%0d tl=%h fb=%0d wav=%b con=%b want 3/28/0/1/1",
                     ksl, tl, fb, wav, con);
        end
        n_tests++;
        if ({ar, dr, sl, rr} !== 16'h3781) begin
            n_fail++; $display("FAIL car_env: got %h want 3781", {ar, dr, sl, rr});
        end
    endtask

    task automatic test_read_before_write();
        wr(6'h12, 8'h11);
        step_to(2, 0);
        @(negedge clk); cen = 1'b1; cpu_we = 1'b1; cpu_addr = 6'h12; cpu_din = 8'h77;
        @(negedge clk); cen = 1'b0; cpu_we = 1'b0;
        adv_model();
        n_tests++;
        if ({ch, op, fnum} !== {4'd2, 1'b0, 9'h011}) begin
            n_fail++;
            $display("FAIL rbw_same_clk: ch=%0d op=%0d fnum=%h want 2/0/011", ch, op, fnum);
        end
        step();
        n_tests++;
        if ({ch, op, fnum} !== {4'd2, 1'b1, 9'h011}) begin
            n_fail++;
            $display("FAIL rbw_carrier_snapshot: ch=%0d op=%0d fnum=%h want 2/1/011", ch, op, fnum);
        end
        step_to(2, 0);
        step();
        n_tests++;
        if ({ch, op, fnum} !== {4'd2, 1'b0, 9'h077}) begin
            n_fail++;
            $display("FAIL rbw_next_visit: ch=%0d op=%0d fnum=%h want 2/0/077", ch, op, fnum);
        end
    endtask

    task automatic test_rhythm();
        pload(16, 4, 8'hF0);
        wr(6'h37, 8'h50);
        wr(6'h0E, 8'h30);
        step_to(6, 0);
        step();
        n_tests++;
        if ({ch, op, ar, keyon, con} !== {4'd6, 1'b0, 4'hF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rhy_bd_mod: ch=%0d op=%0d ar=%h keyon=%b con=%b want 6/0/F/1/0",
                     ch, op, ar, keyon, con);
        end
        step();
        n_tests++;
        if ({ch, op, ar, keyon, con} !== {4'd6, 1'b1, 4'h0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL rhy_bd_car: ch=%0d op=%0d ar=%h keyon=%b con=%b want 6/1/0/1/1",
                     ch, op, ar, keyon, con);
        end
        step();
        n_tests++;
        if ({ch, op, tl, keyon, con} !== {4'd7, 1'b0, 6'h14, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rhy_hh: ch=%0d op=%0d tl=%h keyon=%b con=%b want 7/0/14/0/1",
                     ch, op, tl, keyon, con);
        end
        step_to(6, 0);
        step();
        wr(6'h0E, 8'h00);
        step();
        n_tests++;
        if ({ch, op, keyon, con} !== {4'd6, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL rhy_clear_same_ch: ch=%0d op=%0d keyon=%b con=%b want 6/1/1/1",
                     ch, op, keyon, con);
        end
        step();
        n_tests++;
        if ({ch, op, tl, keyon, con} !== {4'd7, 1'b0, 6'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rhy_clear_next_ch: ch=%0d op=%0d tl=%h keyon=%b con=%b want 7/0/00/0/0",
                     ch, op, tl, keyon, con);
        end
    endtask

    task automatic test_ch12();
        int zcnt = 0;
        do_reset();
        wr(6'h1B, 8'h99); wr(6'h2B, 8'h13);
        wr(6'h1C, 8'hEE); wr(6'h2C, 8'h13);
        for (int i = 0; i < 24; i++) begin
            step12();
            if (x_zero === 1'b1) zcnt++;
            n_tests++;
            if ({x_ch, x_op} !== {4'(i / 2), 1'(i % 2)}) begin
                n_fail++;
                $display("FAIL ch12_walk slot %0d: ch/op=%0d/%0d want %0d/%0d",
                         i, x_ch, x_op, i / 2, i % 2);
            end
            if (i / 2 == 11) begin
                n_tests++;
                if ({x_fnum, x_block, x_keyon} !== {9'h199, 3'd1, 1'b1}) begin
                    n_fail++;
                    $display("FAIL ch12_ch11 slot %0d: fnum=%h block=%0d keyon=%b want 199/1/1",
                             i, x_fnum, x_block, x_keyon);
                end
            end else begin
                n_tests++;
                if ({x_fnum, x_keyon} !== {9'h000, 1'b0}) begin
                    n_fail++;
                    $display("FAIL ch12_ignored slot %0d: fnum=%h keyon=%b want 000/0",
                             i, x_fnum, x_keyon);
                end
            end
        end
        n_tests++;
        if (zcnt != 1) begin
            n_fail++; $display("FAIL ch12_zero_count: got %0d want 1", zcnt);
        end
        step12();
        n_tests++;
        if ({x_zero, x_ch, x_op} !== {1'b1, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL ch12_wrap: zero=%b ch=%0d op=%0d want 1/0/0", x_zero, x_ch, x_op);
        end
    endtask

`ifdef JTOPLL_RDBACK_EN
    task automatic test_rdback();
        wr(6'h33, 8'h7C);
        @(negedge clk); cpu_addr = 6'h33; #1;
        n_tests++;
        if (rd_data !== 8'h7C) begin
            n_fail++; $display("FAIL rdback_ins: got %h want 7C", rd_data);
        end
        @(negedge clk); cpu_addr = 6'h3F; #1;
        n_tests++;
        if (rd_data !== 8'hFF) begin
            n_fail++; $display("FAIL rdback_unmapped_ch: got %h want FF", rd_data);
        end
        @(negedge clk); cpu_addr = 6'h09; #1;
        n_tests++;
        if (rd_data !== 8'hFF) begin
            n_fail++; $display("FAIL rdback_undecoded: got %h want FF", rd_data);
        end
        do_reset();
        @(negedge clk); cpu_addr = 6'h33; #1;
        n_tests++;
        if (rd_data !== 8'h00) begin
            n_fail++; $display("FAIL rdback_after_reset: got %h want 00", rd_data);
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        do_reset();
        pload(3, 0, 8'h21);
        wr(6'h30, 8'h30);
        step();
        n_tests++;
        if ({ch, op, mul} !== {4'd0, 1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL midrst_pre: ch=%0d op=%0d mul=%h want 0/0/1", ch, op, mul);
        end
        repeat (4) step();
        @(negedge clk); #2 rst = 1'b1; #1;
        n_tests++;
        if ({zero, ch, op, fnum, mul, con} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: zero=%b ch=%0d op=%0d mul=%h con=%b want 0",
                     zero, ch, op, mul, con);
        end
        @(negedge clk); rst = 1'b0;
        nxt_ch = 0; nxt_op = 0;
        wr(6'h30, 8'h30);
        step();
        n_tests++;
        if ({zero, ch, op, mul} !== {1'b1, 4'd0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL midrst_restart: zero=%b ch=%0d op=%0d mul=%h want 1/0/0/0 (patch lost)",
                     zero, ch, op, mul);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_params();
        test_read_before_write();
        test_rhythm();
        test_ch12();
`ifdef JTOPLL_RDBACK_EN
        test_rdback();
`endif
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
